// File: rtl/fifo_rd_stream.sv
// Read-side adapter: drains an async FIFO read port into a valid/ready stream,
// using a 2-entry buffer to hide the FIFO's one-cycle read latency.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            level_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            level_q, level_d;
    logic                  inflight_q, inflight_d;
    logic                  valid_q, valid_d;
    logic                  pop;
    logic [1:0]            credits;

    always_comb begin
        pop     = valid_q & m_ready_i;
        credits = level_q + {1'b0, inflight_q};
        // A pop frees a slot this cycle, so a read may be issued at full credit.
        fifo_rd_en_o = rstn_i & ~flush_i & ~fifo_empty_i &
                       ((credits < 2'd2) | ((credits == 2'd2) & pop));

        head_d     = head_q;
        tail_d     = tail_q;
        level_d    = level_q;
        inflight_d = fifo_rd_en_o;

        if (flush_i) begin
            level_d = '0;
        end else begin
            case (level_q)
                2'd0: begin
                    if (inflight_q) begin
                        head_d  = fifo_rd_data_i;
                        level_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight_q && pop) begin
                        head_d = fifo_rd_data_i;
                    end else if (inflight_q) begin
                        tail_d  = fifo_rd_data_i;
                        level_d = 2'd2;
                    end else if (pop) begin
                        level_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_d = tail_q;
                        if (inflight_q) begin
                            tail_d = fifo_rd_data_i;
                        end else begin
                            level_d = 2'd1;
                        end
                    end
                end
                default: level_d = '0;
            endcase
        end

        valid_d = (level_d != 2'd0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
        end
    end

    assign m_valid_o = valid_q;
    assign m_data_o  = head_q;
    assign level_o   = level_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(inflight_q && (level_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read-port model.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rstn;
    logic       flush;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = '0;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] level;

    int n_total = 0;
    int n_bad   = 0;

    fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .flush_i        (flush),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_en_o   (fifo_rd_en),
        .fifo_rd_data_i (fifo_rd_data),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_data_o       (m_data),
        .level_o        (level)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:255];
    int unsigned wr_idx = 0;
    int unsigned rd_idx = 0;
    int          rd_cnt = 0;
    int          viol   = 0;
    int          max_lvl = 0;
    logic        tb_inflight = 1'b0;
    logic [7:0]  got [$];

    assign fifo_empty = (rd_idx == wr_idx);

    // FIFO read port model; the FIFO shares rstn and drops its contents in reset.
    always @(posedge clk) begin
        if (!rstn) begin
            rd_idx      <= wr_idx;
            tb_inflight <= 1'b0;
        end else begin
            if (fifo_rd_en && !fifo_empty) begin
                fifo_rd_data <= mem[rd_idx[7:0]];
                rd_idx       <= rd_idx + 1;
                rd_cnt       <= rd_cnt + 1;
                if ((int'(level) + int'(tb_inflight)) >= 2 && !(m_valid && m_ready))
                    viol <= viol + 1;
            end
            tb_inflight <= fifo_rd_en && !fifo_empty;
            if (m_valid && m_ready) got.push_back(m_data);
            if (int'(level) > max_lvl) max_lvl <= int'(level);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_idx[7:0]] = v;
        wr_idx = wr_idx + 1;
    endtask

    task automatic wait_pops(input int base, input int n);
        for (int i = 0; i < 100; i++) begin
            if (got.size() >= base + n) break;
            @(negedge clk);
        end
        check("pop_count", got.size() - base, n);
    endtask

    int base;
    int rbase;

    initial begin
        rstn = 1'b0; flush = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_level", level, 0);
        push(8'h99);
        #1 check("rst_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rd_en", fifo_rd_en, 0);

        // single word
        m_ready = 1'b1;
        rbase = rd_cnt;
        push(8'hA5);
        #1 check("single_rd_en", fifo_rd_en, 1);
        @(negedge clk);
        check("single_rd_en_off", fifo_rd_en, 0);
        check("single_wait", m_valid, 0);
        @(negedge clk);
        check("single_valid", m_valid, 1);
        check("single_data", m_data, 8'hA5);
        check("single_level", level, 1);
        @(negedge clk);
        check("single_done_valid", m_valid, 0);
        check("single_done_level", level, 0);
        check("single_reads", rd_cnt - rbase, 1);

        // streaming
        for (int i = 1; i <= 8; i++) push(8'(i));
        @(negedge clk);
        check("stream_startup", m_valid, 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("stream_word", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'(i)});
        end
        @(negedge clk);
        check("stream_end", m_valid, 0);

        // backpressure
        m_ready = 1'b0;
        base  = got.size();
        rbase = rd_cnt;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        repeat (10) begin
            @(negedge clk);
            if (m_valid) check("bp_held", m_data, 8'h10);
        end
        check("bp_reads", rd_cnt - rbase, 2);
        check("bp_level", level, 2);
        check("bp_data", m_data, 8'h10);
        m_ready = 1'b1;
        wait_pops(base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < got.size()) check("bp_order", got[base + i], 8'h10 + 8'(i));

        // ready toggling
        base = got.size();
        viol = 0;
        max_lvl = 0;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        for (int i = 0; i < 40; i++) begin
            m_ready = ~m_ready;
            @(negedge clk);
        end
        m_ready = 1'b1;
        wait_pops(base, 16);
        for (int i = 0; i < 16; i++)
            if (base + i < got.size()) check("tog_order", got[base + i], 8'h20 + 8'(i));
        check("tog_max_level", max_lvl <= 2, 1);
        check("tog_credit_viol", viol, 0);
        repeat (2) @(negedge clk);

        // flush with a word in flight
        m_ready = 1'b0;
        base = got.size();
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        @(negedge clk);
        @(negedge clk);
        check("fl_pre_valid", m_valid, 1);
        check("fl_pre_data", m_data, 8'h30);
        flush = 1'b1;
        #1 check("fl_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        flush = 1'b0;
        check("fl_valid", m_valid, 0);
        check("fl_level", level, 0);
        m_ready = 1'b1;
        @(negedge clk);
        check("fl_resume_wait", m_valid, 0);
        @(negedge clk);
        check("fl_resume0", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'h32});
        @(negedge clk);
        check("fl_resume1", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'h33});
        @(negedge clk);
        check("fl_pops", got.size() - base, 2);
        if (got.size() > base) check("fl_first", got[base], 8'h32);

        // reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
        repeat (4) @(negedge clk);
        check("rm_level_pre", level, 2);
        #3 rstn = 1'b0;
        #1;
        check("rm_valid", m_valid, 0);
        check("rm_data", m_data, 0);
        check("rm_level", level, 0);
        check("rm_rd_en", fifo_rd_en, 0);
        repeat (3) @(negedge clk);
        check("rm_rd_en_hold", fifo_rd_en, 0);
        m_ready = 1'b1;
        rstn = 1'b1;
        push(8'h40);
        @(negedge clk);
        check("rm_post_wait", m_valid, 0);
        @(negedge clk);
        check("rm_post", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'h40});
        @(negedge clk);
        check("rm_post_empty", m_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
